// File: rtl/score_controller.sv
// Game-flow sequencer owning both scores; score changes commit only on FRAME_START.
// Optional SCORE_BLINK_EN: scores blink every 16 frames while in game over.
module score_controller #(
  parameter int WIN_SCORE    = 11,
  parameter int WIN_BY       = 2,
  parameter int MAX_SCORE    = 99,
  parameter int SERVE_CHANGE = 2,
  parameter int HOLD_FRAMES  = 60,
  parameter int SERVE_FRAMES = 30
) (
  input  logic       VGA_CLK,
  input  logic       RST_N,
  input  logic       FRAME_START,
  input  logic       START,
  input  logic       CLEAR,
  input  logic       POINT_A,
  input  logic       POINT_B,
  output logic [6:0] ScoreA,
  output logic [6:0] ScoreB,
  output logic       SERVE_SIDE,
  output logic       BALL_EN,
  output logic       GAME_OVER,
  output logic       WINNER,
  output logic       SCORE_VISIBLE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int FMAX = (HOLD_FRAMES > SERVE_FRAMES) ? HOLD_FRAMES : SERVE_FRAMES;
  localparam int FCW  = $clog2(FMAX + 1);
  localparam int SCW  = (SERVE_CHANGE > 1) ? $clog2(SERVE_CHANGE + 1) : 1;

  localparam logic [FCW-1:0] HOLD_L  = FCW'(HOLD_FRAMES);
  localparam logic [FCW-1:0] SERVE_L = FCW'(SERVE_FRAMES);
  localparam logic [SCW-1:0] SC_L    = SCW'(SERVE_CHANGE);
  localparam logic [6:0]     MAX7    = 7'(MAX_SCORE);
  localparam logic [7:0]     WIN8    = 8'(WIN_SCORE);
  localparam logic [7:0]     BY8     = 8'(WIN_BY);

  logic [2:0]     state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d, fcnt_inc;
  logic [SCW-1:0] scnt_q, scnt_d, scnt_inc;
  logic           pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [6:0]     score_a_q, score_a_d, score_b_q, score_b_d;
  logic           side_q, side_d, winner_q, winner_d;
  logic           ball_q, over_q;
  logic [6:0]     next_a, next_b;
  logic [7:0]     next_a8, next_b8;
  logic           win_a, win_b;

  assign fcnt_inc = fcnt_q + FCW'(1);
  assign scnt_inc = scnt_q + SCW'(1);

  // Post-commit scores feed the win check on the same cycle they are committed.
  assign next_a  = (pend_a_q && score_a_q != MAX7) ? score_a_q + 7'd1 : score_a_q;
  assign next_b  = (pend_b_q && score_b_q != MAX7) ? score_b_q + 7'd1 : score_b_q;
  assign next_a8 = {1'b0, next_a};
  assign next_b8 = {1'b0, next_b};
  assign win_a   = (next_a8 >= WIN8 && next_a8 >= next_b8 + BY8) || next_a == MAX7;
  assign win_b   = (next_b8 >= WIN8 && next_b8 >= next_a8 + BY8) || next_b == MAX7;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    scnt_d    = scnt_q;
    pend_a_d  = pend_a_q;
    pend_b_d  = pend_b_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    side_d    = side_q;
    winner_d  = winner_q;
    if (CLEAR) begin
      state_d   = S_IDLE;
      fcnt_d    = '0;
      scnt_d    = '0;
      pend_a_d  = 1'b0;
      pend_b_d  = 1'b0;
      score_a_d = '0;
      score_b_d = '0;
      side_d    = 1'b0;
      winner_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_SERVE;
            fcnt_d  = '0;
          end
        end
        S_SERVE: begin
          if (FRAME_START) begin
            if (fcnt_inc == SERVE_L) begin
              state_d = S_PLAY;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_inc;
            end
          end
        end
        S_PLAY: begin
          if (POINT_A || POINT_B) begin
            // Simultaneous pulses mean a replayed rally: hold without a pending point.
            state_d  = S_HOLD;
            fcnt_d   = '0;
            pend_a_d = POINT_A & ~POINT_B;
            pend_b_d = POINT_B & ~POINT_A;
          end
        end
        S_HOLD: begin
          if (FRAME_START) begin
            fcnt_d = fcnt_inc;
            if (fcnt_inc == HOLD_L) begin
              state_d = S_SERVE;
              fcnt_d  = '0;
            end
            if (fcnt_q == '0) begin
              score_a_d = next_a;
              score_b_d = next_b;
              pend_a_d  = 1'b0;
              pend_b_d  = 1'b0;
              if (pend_a_q || pend_b_q) begin
                if (scnt_inc == SC_L) begin
                  scnt_d = '0;
                  side_d = ~side_q;
                end else begin
                  scnt_d = scnt_inc;
                end
              end
              if (win_a || win_b) begin
                state_d  = S_OVER;
                winner_d = win_b;
                fcnt_d   = '0;
              end
            end
          end
        end
        S_OVER: begin
          if (START) begin
            state_d   = S_SERVE;
            fcnt_d    = '0;
            scnt_d    = '0;
            score_a_d = '0;
            score_b_d = '0;
            side_d    = ~side_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      scnt_q    <= '0;
      pend_a_q  <= 1'b0;
      pend_b_q  <= 1'b0;
      score_a_q <= '0;
      score_b_q <= '0;
      side_q    <= 1'b0;
      winner_q  <= 1'b0;
      ball_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      scnt_q    <= scnt_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      side_q    <= side_d;
      winner_q  <= winner_d;
      ball_q    <= (state_d == S_PLAY);
      over_q    <= (state_d == S_OVER);
    end
  end

`ifdef SCORE_BLINK_EN
  logic [3:0] blink_q;
  logic       vis_q;

  always_ff @(posedge VGA_CLK) begin
    if (!RST_N || state_q != S_OVER || state_d != S_OVER) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else if (FRAME_START) begin
      blink_q <= blink_q + 4'd1;
      if (&blink_q) vis_q <= ~vis_q;
    end
  end

  assign SCORE_VISIBLE = vis_q;
`else
  assign SCORE_VISIBLE = 1'b1;
`endif

  assign ScoreA     = score_a_q;
  assign ScoreB     = score_b_q;
  assign SERVE_SIDE = side_q;
  assign BALL_EN    = ball_q;
  assign GAME_OVER  = over_q;
  assign WINNER     = winner_q;

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
Game-flow sequencer that owns the two 7-bit scores consumed by the score overlay and the ball/paddle logic. Accepts point pulses from ball logic and the start button, and runs the serve / play / point-hold / game-over sequence. Commits score changes only on a frame boundary so the overlay never shows a torn digit. Sits between ball logic and the score overlay, clocked by the pixel clock.

Parameters:
WIN_SCORE, 11, score a player must reach to win (with WIN_BY lead)
WIN_BY, 2, minimum lead required to win
MAX_SCORE, 99, saturation value; reaching it wins regardless of lead
SERVE_CHANGE, 2, total points between serve-side swaps
HOLD_FRAMES, 60, frames spent in POINT_HOLD after a point
SERVE_FRAMES, 30, frames spent in SERVE before the ball is released

Ports:
VGA_CLK  in  1  pixel clock, sole clock
RST_N  in  1  synchronous active-low reset
FRAME_START  in  1  one-cycle pulse at start of each frame (vertical blank)
START  in  1  one-cycle start/restart pulse (debounced upstream)
CLEAR  in  1  synchronous soft clear, any state
POINT_A  in  1  one-cycle pulse: player A scored
POINT_B  in  1  one-cycle pulse: player B scored
ScoreA  out  7  committed score A, 0..MAX_SCORE
ScoreB  out  7  committed score B, 0..MAX_SCORE
SERVE_SIDE  out  1  0 = A serves, 1 = B serves
BALL_EN  out  1  high only in PLAY; ball logic moves ball when high
GAME_OVER  out  1  high in GAME_OVER state
WINNER  out  1  0 = A, 1 = B; valid while GAME_OVER
SCORE_VISIBLE  out  1  overlay enable for scores

Behaviour:
- Reset (RST_N low at VGA_CLK edge): state IDLE, ScoreA = ScoreB = 0, SERVE_SIDE = 0, BALL_EN = 0, GAME_OVER = 0, WINNER = 0, SCORE_VISIBLE = 1; pending point flags, frame counter and serve counter cleared. Reset mid-game abandons all state.
- States: IDLE, SERVE, PLAY, POINT_HOLD, GAME_OVER. All outputs registered.
- IDLE: START -> SERVE next cycle; scores stay 0.
- SERVE: frame counter counts FRAME_START pulses. After SERVE_FRAMES pulses -> PLAY. BALL_EN rises on the cycle after the transition.
- PLAY: a POINT_A or POINT_B pulse sets the matching pending flag and moves to POINT_HOLD; BALL_EN drops on the next cycle. POINT_A and POINT_B in the same cycle = replayed rally: no pending flag, go to POINT_HOLD.
- Point pulses outside PLAY are ignored.
- Commit: on the first FRAME_START in POINT_HOLD, the pending flag adds 1 to the score (saturating at MAX_SCORE) and clears, and the serve counter increments.
  - When the serve counter reaches SERVE_CHANGE, it wraps to 0 and SERVE_SIDE toggles.
  - Scores never change except on a FRAME_START cycle, on CLEAR, or on the START that leaves GAME_OVER.
- Win check uses post-commit values on the commit cycle. A player wins if (score >= WIN_SCORE and score - other >= WIN_BY) or score == MAX_SCORE.
  - Win -> GAME_OVER next cycle: WINNER set, GAME_OVER = 1.
  - Otherwise POINT_HOLD counts HOLD_FRAMES frames (including the commit frame), then -> SERVE.
- GAME_OVER: scores hold. START -> both scores 0, SERVE_SIDE toggles (loser of previous game does not matter; simple alternation), serve counter 0, state SERVE.
- CLEAR (any state, higher priority than START and points): -> IDLE with reset values except SERVE_SIDE = 0.
- Priority in one cycle: RST_N > CLEAR > commit/START > point pulses.

Optional Feature:
SCORE_BLINK_EN:
- Defined: in GAME_OVER, SCORE_VISIBLE toggles every 16 FRAME_START pulses (starting at 1 on entry). In all other states it is 1.
- Undefined: SCORE_VISIBLE is constant 1; blink counter logic is absent.

Test Plan:
- Reset, START, 30 FRAME_START pulses -> PLAY, BALL_EN = 1 one cycle after the 30th pulse; ScoreA = ScoreB = 0.
- In PLAY, POINT_A, then FRAME_START 5 cycles later -> BALL_EN = 0 next cycle; ScoreA stays 0 until the FRAME_START cycle, becomes 1 after it; back to SERVE after 60 frames.
- Play 4 points (A,B,A,A) -> SERVE_SIDE toggles after the 2nd and 4th commits: values 0,0,1,1,0.
- Drive to 10-10, then A, A -> 11-10 stays in play (no win); 12-10 -> GAME_OVER = 1, WINNER = 0. START -> scores 0, SERVE state.
- POINT_A and POINT_B in the same cycle at 3-3 -> POINT_HOLD, scores remain 3-3, serve counter unchanged. CLEAR during PLAY -> IDLE, scores 0, BALL_EN = 0 next cycle.
- With SCORE_BLINK_EN: in GAME_OVER, SCORE_VISIBLE = 1 for frames 0-15, 0 for 16-31, 1 again at 32. Without SCORE_BLINK_EN: constant 1.
